mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_if.sv | 15 +
 rtl/mdu.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared pipeline definitions: MDU op codes and default MDU latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_if.sv
// E-stage to MDU bundle: op request, forwarded operands, busy and read data.
interface mdu_if;
  import mdu_pkg::*;

  logic        start;
  mdu_op_e     op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] E_PC;
  logic        busy;
  logic [31:0] out;

  modport master (output start, op, A, B, E_PC, input busy, out);
  modport slave  (input start, op, A, B, E_PC, output busy, out);
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy counter.
// Optional trace of HI/LO commits when MDU_TRACE_EN is defined.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  logic [31:0] hi_r, lo_r, pend_hi_r, pend_lo_r, cnt_r;
  logic        pend_wr_r;
  logic        idle_s, commit_s;
  logic [63:0] prod_u_s, prod_s_s;
  logic [31:0] a_mag_s, b_mag_s, mag_q_s, mag_r_s;
  logic [31:0] uq_s, ur_s, sq_s, sr_s, out_s;

  // Datapath: products and quotient/remainder from the current operands.
  always_comb begin
    prod_u_s = {32'd0, bus.A} * {32'd0, bus.B};
    prod_s_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    a_mag_s  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
    b_mag_s  = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
    if (bus.B != 32'd0) begin
      uq_s    = bus.A / bus.B;
      ur_s    = bus.A % bus.B;
      mag_q_s = a_mag_s / b_mag_s;
      mag_r_s = a_mag_s % b_mag_s;
    end else begin
      uq_s    = 32'd0;
      ur_s    = 32'd0;
      mag_q_s = 32'd0;
      mag_r_s = 32'd0;
    end
    // Sign applied to magnitudes: quotient truncates toward zero, remainder follows dividend.
    sq_s = (bus.A[31] ^ bus.B[31]) ? (~mag_q_s + 32'd1) : mag_q_s;
    sr_s = bus.A[31] ? (~mag_r_s + 32'd1) : mag_r_s;
  end

  // Control decode: idle when counter is zero, commit on the last busy edge.
  always_comb begin
    idle_s   = (cnt_r == 32'd0);
    commit_s = (cnt_r == 32'd1) && pend_wr_r;
  end

  // HI/LO, pending result and busy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
      cnt_r     <= 32'd0;
    end else if (!idle_s) begin
      cnt_r <= cnt_r - 32'd1;
      if (commit_s) begin
        hi_r <= pend_hi_r;
        lo_r <= pend_lo_r;
      end
    end else if (bus.start) begin
      case (bus.op)
        MDU_MULT: begin
          pend_hi_r <= prod_s_s[63:32];
          pend_lo_r <= prod_s_s[31:0];
          pend_wr_r <= 1'b1;
          cnt_r     <= 32'(MULT_CYCLES);
        end
        MDU_MULTU: begin
          pend_hi_r <= prod_u_s[63:32];
          pend_lo_r <= prod_u_s[31:0];
          pend_wr_r <= 1'b1;
          cnt_r     <= 32'(MULT_CYCLES);
        end
        MDU_DIV: begin
          pend_hi_r <= sr_s;
          pend_lo_r <= sq_s;
          pend_wr_r <= (bus.B != 32'd0);
          cnt_r     <= 32'(DIV_CYCLES);
        end
        MDU_DIVU: begin
          pend_hi_r <= ur_s;
          pend_lo_r <= uq_s;
          pend_wr_r <= (bus.B != 32'd0);
          cnt_r     <= 32'(DIV_CYCLES);
        end
        MDU_MTHI: hi_r <= bus.A;
        MDU_MTLO: lo_r <= bus.A;
        default:  cnt_r <= 32'd0;
      endcase
    end
  end

  // Read port: combinational HI/LO select, stale while busy.
  always_comb begin
    case (bus.op)
      MDU_MFHI: out_s = hi_r;
      MDU_MFLO: out_s = lo_r;
      default:  out_s = 32'd0;
    endcase
  end

  assign bus.busy = !idle_s;
  assign bus.out  = out_s;

`ifdef MDU_TRACE_EN
  logic [31:0] pc_r;

  // Latch the issuing PC at accept and report every HI/LO commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= 32'd0;
    end else begin
      if (idle_s && bus.start) pc_r <= bus.E_PC;
      else                     pc_r <= pc_r;
      if (commit_s) begin
        $display("%0t@%08h: $hi <= %08h", $time, pc_r, pend_hi_r);
        $display("%0t@%08h: $lo <= %08h", $time, pc_r, pend_lo_r);
      end else if (idle_s && bus.start && bus.op == MDU_MTHI) begin
        $display("%0t@%08h: $hi <= %08h", $time, bus.E_PC, bus.A);
      end else if (idle_s && bus.start && bus.op == MDU_MTLO) begin
        $display("%0t@%08h: $lo <= %08h", $time, bus.E_PC, bus.A);
      end
    end
  end
`else
  logic unused_pc_s;
  assign unused_pc_s = ^bus.E_PC;
`endif

endmodule
